// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: ALU and mul/div funct3 encodings, the
// mul/div control state enum and small operand-classification helpers.
package ex_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic md_src1_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_src2_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the EX pipeline (master) and the
// iterative mul/div unit (slave).
interface ex_muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_src1;
  logic [XLEN-1:0]  in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/ex_muldiv_step.sv
// One combinational bit step: shift-add multiply (hi:lo accumulator, lo holds
// the remaining multiplier) or restoring divide (hi = partial remainder, lo = quotient).
module ex_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);
  logic [XLEN:0] sum_s;
  logic [XLEN:0] rem_s;
  logic [XLEN:0] diff_s;

  // Next accumulator for one multiply or divide bit.
  always_comb begin
    sum_s  = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    rem_s  = {hi, lo[XLEN-1]};
    diff_s = rem_s - {1'b0, operand};
    if (is_div) begin
      // Borrow out of the trial subtraction means the divisor did not fit.
      if (!diff_s[XLEN]) begin
        hi_next = diff_s[XLEN-1:0];
      end else begin
        hi_next = rem_s[XLEN-1:0];
      end
      lo_next = {lo[XLEN-2:0], ~diff_s[XLEN]};
    end else begin
      hi_next = sum_s[XLEN:1];
      lo_next = {sum_s[0], lo[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: operands are converted to
// magnitudes on accept, STEPS bits resolved per CALC cycle, sign fixed at the end.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int STEPS = 1,
  parameter int TAG_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);
  localparam int ITERS = XLEN / STEPS;
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  X_ZERO   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  X_ONES   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  X_MIN    = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  md_state_e         state_r;
  logic [2:0]        op_r;
  logic              neg_r;
  logic [XLEN-1:0]   hi_r;
  logic [XLEN-1:0]   lo_r;
  logic [XLEN-1:0]   opnd_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              out_valid_r;
  logic [XLEN-1:0]   out_result_r;
  logic [TAG_W-1:0]  out_tag_r;

  logic              accept_s;
  logic              neg1_s;
  logic              neg2_s;
  logic [XLEN-1:0]   mag1_s;
  logic [XLEN-1:0]   mag2_s;
  logic              div_zero_s;
  logic              ovf_s;
  logic [XLEN-1:0]   fast_res_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   div_val_s;
  logic [XLEN-1:0]   final_s;

  logic [XLEN-1:0]   hi_c [STEPS+1];
  logic [XLEN-1:0]   lo_c [STEPS+1];

  assign bus.in_ready   = (state_r == MD_IDLE);
  assign bus.out_valid  = out_valid_r;
  assign bus.out_result = out_result_r;
  assign bus.out_tag    = out_tag_r;

  // Request decode: operand magnitudes and the two fast-path special cases.
  always_comb begin
    accept_s   = bus.in_valid & (state_r == MD_IDLE) & ~bus.flush;
    neg1_s     = md_src1_signed(bus.in_op) & bus.in_src1[XLEN-1];
    neg2_s     = md_src2_signed(bus.in_op) & bus.in_src2[XLEN-1];
    mag1_s     = neg1_s ? neg_x(bus.in_src1) : bus.in_src1;
    mag2_s     = neg2_s ? neg_x(bus.in_src2) : bus.in_src2;
    div_zero_s = md_is_div(bus.in_op) & (bus.in_src2 == X_ZERO);
    ovf_s      = md_is_div(bus.in_op) & md_src1_signed(bus.in_op) &
                 (bus.in_src1 == X_MIN) & (bus.in_src2 == X_ONES);
    if (div_zero_s) begin
      fast_res_s = bus.in_op[1] ? bus.in_src1 : X_ONES;
    end else if (ovf_s) begin
      fast_res_s = bus.in_op[1] ? X_ZERO : X_MIN;
    end else begin
      fast_res_s = X_ZERO;
    end
  end

  assign hi_c[0] = hi_r;
  assign lo_c[0] = lo_r;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    ex_muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div  (op_r[2]),
      .hi      (hi_c[g]),
      .lo      (lo_c[g]),
      .operand (opnd_r),
      .hi_next (hi_c[g+1]),
      .lo_next (lo_c[g+1])
    );
  end

  // Sign fix and result select applied to the output of the last chain step.
  always_comb begin
    prod_s = {hi_c[STEPS], lo_c[STEPS]};
    if (neg_r) begin
      prod_s = neg_2x(prod_s);
    end else begin
      prod_s = {hi_c[STEPS], lo_c[STEPS]};
    end
    div_val_s = op_r[1] ? hi_c[STEPS] : lo_c[STEPS];
    if (op_r[2]) begin
      final_s = neg_r ? neg_x(div_val_s) : div_val_s;
    end else if (op_r == MD_MUL) begin
      final_s = prod_s[XLEN-1:0];
    end else begin
      final_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Control FSM with datapath and output registers; flush beats every other event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= MD_IDLE;
      op_r         <= 3'b000;
      neg_r        <= 1'b0;
      hi_r         <= X_ZERO;
      lo_r         <= X_ZERO;
      opnd_r       <= X_ZERO;
      cnt_r        <= {CNT_W{1'b0}};
      out_valid_r  <= 1'b0;
      out_result_r <= X_ZERO;
      out_tag_r    <= {TAG_W{1'b0}};
    end else if (bus.flush) begin
      state_r     <= MD_IDLE;
      out_valid_r <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (accept_s) begin
            op_r      <= bus.in_op;
            out_tag_r <= bus.in_tag;
            // Remainder takes the dividend's sign; product and quotient take s1^s2.
            neg_r     <= (md_is_div(bus.in_op) & bus.in_op[1]) ? neg1_s : (neg1_s ^ neg2_s);
            hi_r      <= X_ZERO;
            cnt_r     <= {CNT_W{1'b0}};
            if (md_is_div(bus.in_op)) begin
              lo_r   <= mag1_s;
              opnd_r <= mag2_s;
            end else begin
              lo_r   <= mag2_s;
              opnd_r <= mag1_s;
            end
            if (div_zero_s | ovf_s) begin
              state_r      <= MD_DONE;
              out_valid_r  <= 1'b1;
              out_result_r <= fast_res_s;
            end else begin
              state_r <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          hi_r <= hi_c[STEPS];
          lo_r <= lo_c[STEPS];
          if (cnt_r == CNT_LAST) begin
            state_r      <= MD_DONE;
            out_valid_r  <= 1'b1;
            out_result_r <= final_s;
            cnt_r        <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        MD_DONE: begin
          if (bus.out_ready) begin
            state_r     <= MD_IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= MD_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed vectors push expected results,
// a negedge monitor pops and compares on each output transfer.
module tb_ex_muldiv;
  import ex_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  ex_muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus4 ();

  ex_muldiv #(.XLEN(XLEN), .STEPS(1), .TAG_W(TAG_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ex_muldiv #(.XLEN(XLEN), .STEPS(4), .TAG_W(TAG_W)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next posedge when valid & ready & ~flush.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready && !bus.flush) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        check("result", bus.out_result, e.res);
        check("tag", bus.out_tag, e.tag);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check("idle_timeout", bus.in_ready, 1'b1);
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_src1  = a;
    bus.in_src2  = b;
    bus.in_tag   = tag;
    tick();
    // Scramble request fields after the accept edge; the unit must ignore them.
    bus.in_valid = 1'b0;
    bus.in_op    = ~op;
    bus.in_src1  = ~a;
    bus.in_src2  = a ^ b;
    bus.in_tag   = ~tag;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                     input int lat);
    int n;
    wait_idle();
    sb_q.push_back('{res: exp, tag: tag});
    send(op, a, b, tag);
    wait_valid(n);
    check({name, "_latency"}, 64'(n), 64'(lat));
    tick();
  endtask

  task automatic run4(input string name, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    int n = 0;
    bus4.in_valid = 1'b1;
    bus4.in_op    = op;
    bus4.in_src1  = a;
    bus4.in_src2  = b;
    bus4.in_tag   = tag;
    tick();
    bus4.in_valid = 1'b0;
    bus4.in_src1  = ~a;
    while (!bus4.out_valid && n < 100) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'd8);
    check({name, "_result"}, bus4.out_result, exp);
    check({name, "_tag"}, bus4.out_tag, tag);
    tick();
  endtask

  initial begin
    int  n;
    logic seen;
    bus.in_valid  = 1'b0;  bus.in_op  = 3'b000; bus.in_src1  = 32'd0; bus.in_src2  = 32'd0;
    bus.in_tag    = 5'd0;  bus.flush  = 1'b0;   bus.out_ready  = 1'b1;
    bus4.in_valid = 1'b0;  bus4.in_op = 3'b000; bus4.in_src1 = 32'd0; bus4.in_src2 = 32'd0;
    bus4.in_tag   = 5'd0;  bus4.flush = 1'b0;   bus4.out_ready = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_result", bus.out_result, 32'd0);
    check("rst_out_tag", bus.out_tag, 5'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", bus.in_ready, 1'b1);

    // Multiply family
    run("mul",      MD_MUL,    32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 32);
    run("mul_neg",  MD_MUL,    32'hFFFFFFFD, 32'hFFFFFFFB, 5'd2, 32'd15,       32);
    run("mulh",     MD_MULH,   32'h80000000, 32'h80000000, 5'd3, 32'h40000000, 32);
    run("mulhu",    MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, 32);
    run("mulhsu",   MD_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd5, 32'hFFFFFFFF, 32);

    // Divide family
    run("divu",     MD_DIVU, 32'd100,      32'd7,        5'd6,  32'd14,       32);
    run("remu",     MD_REMU, 32'd100,      32'd7,        5'd7,  32'd2,        32);
    run("div_neg",  MD_DIV,  32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 32);
    run("rem_neg",  MD_REM,  32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, 32);
    run("div_ndiv", MD_DIV,  32'd7,        32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, 32);
    run("rem_ndiv", MD_REM,  32'd7,        32'hFFFFFFFE, 5'd11, 32'd1,        32);
    run("divu_big", MD_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        32);
    run("remu_big", MD_REMU, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 32);

    // Fast paths
    run("div_zero",  MD_DIV,  32'd123,      32'd0,        5'd14, 32'hFFFFFFFF, 0);
    run("rem_zero",  MD_REM,  32'd5,        32'd0,        5'd15, 32'd5,        0);
    run("divu_zero", MD_DIVU, 32'd9,        32'd0,        5'd16, 32'hFFFFFFFF, 0);
    run("div_ovf",   MD_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 0);
    run("rem_ovf",   MD_REM,  32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        0);

    // Backpressure: result held, no new accept while stalled
    wait_idle();
    bus.out_ready = 1'b0;
    sb_q.push_back('{res: 32'd100, tag: 5'd19});
    send(MD_DIVU, 32'd1000, 32'd10, 5'd19);
    wait_valid(n);
    check("bp_latency", 64'(n), 64'd32);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.in_op = MD_DIV; bus.in_src1 = 32'd1; bus.in_src2 = 32'd0;
      bus.in_tag = 5'd31;
      tick();
      check("bp_valid", bus.out_valid, 1'b1);
      check("bp_result", bus.out_result, 32'd100);
      check("bp_tag", bus.out_tag, 5'd19);
      check("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_idle", bus.in_ready, 1'b1);
    run("after_bp", MD_MUL, 32'd6, 32'd7, 5'd22, 32'd42, 32);

    // Flush at CALC iteration 10
    wait_idle();
    send(MD_DIV, 32'd1000, 32'd3, 5'd23);
    for (int i = 0; i < 10; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_calc_idle", bus.in_ready, 1'b1);
    check("flush_calc_valid", bus.out_valid, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | bus.out_valid;
    end
    check("flush_calc_no_valid", seen, 1'b0);
    run("after_flush", MD_DIV, 32'd1000, 32'd3, 5'd24, 32'd333, 32);

    // Flush beats a same-cycle output handshake
    wait_idle();
    bus.out_ready = 1'b0;
    send(MD_DIVU, 32'd9, 32'd0, 5'd25);
    check("flush_done_pre_valid", bus.out_valid, 1'b1);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_done_valid", bus.out_valid, 1'b0);
    check("flush_done_idle", bus.in_ready, 1'b1);

    // Flush beats a same-cycle accept
    bus.in_valid = 1'b1; bus.in_op = MD_DIV; bus.in_src1 = 32'd5; bus.in_src2 = 32'd0;
    bus.in_tag = 5'd26; bus.flush = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush_accept_idle", bus.in_ready, 1'b1);
    check("flush_accept_valid", bus.out_valid, 1'b0);

    // Asynchronous reset in DONE
    bus.out_ready = 1'b0;
    send(MD_REM, 32'd5, 32'd0, 5'd27);
    check("rst_done_pre_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_done_valid", bus.out_valid, 1'b0);
    check("rst_done_result", bus.out_result, 32'd0);
    check("rst_done_tag", bus.out_tag, 5'd0);
    check("rst_done_in_ready", bus.in_ready, 1'b1);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    // Asynchronous reset in CALC
    send(MD_MUL, 32'd3, 32'd3, 5'd28);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    check("rst_calc_in_ready", bus.in_ready, 1'b1);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | bus.out_valid;
    end
    check("rst_calc_no_valid", seen, 1'b0);
    run("after_rst", MD_MULHU, 32'h00010000, 32'h00010000, 5'd29, 32'd1, 32);

    // STEPS=4 instance: 8 CALC cycles
    run4("s4_mul", MD_MUL, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB);
    run4("s4_div", MD_DIV, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD);
    run4("s4_rem", MD_REM, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFF);

    tick();
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
